fpga_ddr3_st_timing_adapter_buf: RTL and testbench

- Parametrised Avalon-ST timing adapter between an upstream source with no ready signal and a downstream sink that can backpressure.
- Replaces the pass-through adapter, which only warned when the sink deasserted ready.
- An internal FIFO absorbs backpressure. The block converts to a downstream ready latency of 0 or 1.
- Sits in the DMA master datapath of the DDR3 subsystem and reports drops and fill level for status/debug.

---
 rtl/fpga_ddr3_st_timing_adapter_buf.sv | 135 +++++++++++++
 tb/tb_fpga_ddr3_st_timing_adapter_buf.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_ddr3_st_timing_adapter_buf.sv
// ---------------------------------------------------------------------------
// fpga_ddr3_st_timing_adapter_buf
//
// Avalon-ST timing adapter for the DDR3 DMA master datapath. The upstream
// source has no ready signal and cannot be stalled, so every beat it offers
// is written into a small circular FIFO. The downstream sink may apply
// backpressure with a ready latency of 0 or 1. Beats that arrive while the
// FIFO is full and not draining are dropped; drops are reported through a
// sticky overflow flag and a saturating counter.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   in_valid       upstream beat valid (never stalled)
//   in_data        upstream payload
//   out_valid      downstream beat valid
//   out_data       downstream payload (don't-care while out_valid is low)
//   out_ready      downstream ready
//   fill_level     entries currently stored, 0..DEPTH
//   almost_full    fill_level >= ALMOST_FULL
//   overflow       sticky: at least one beat was dropped
//   clear_overflow synchronous clear of overflow and drop_count
//   drop_count     saturating count of dropped beats
// ---------------------------------------------------------------------------
module fpga_ddr3_st_timing_adapter_buf #(
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 16,
    parameter int READY_LATENCY = 0,
    parameter int ALMOST_FULL   = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       fill_level,
    output logic                         almost_full,
    output logic                         overflow,
    input  logic                         clear_overflow,
    output logic [15:0]                  drop_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              ready_d;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;

    // Handshake decode. With ready latency 1 the sink promised to accept
    // whatever we present this cycle because it was ready last cycle, so any
    // presented beat is a transfer. With latency 0 the sink's current ready
    // qualifies the transfer, and a pop frees a slot for a same-cycle push
    // even when the FIFO is full.
    always_comb begin
        full      = (count == (AW+1)'(DEPTH));
        out_valid = (count != '0) && ((READY_LATENCY == 0) ? 1'b1 : ready_d);
        pop       = out_valid && ((READY_LATENCY == 0) ? out_ready : 1'b1);
        push      = in_valid && (!full || pop);
        drop      = in_valid && full && !pop;
    end

    // Head of the FIFO is presented directly; there is no bypass path, so a
    // beat becomes visible the cycle after it is written.
    assign out_data    = mem[rd_ptr];
    assign fill_level  = count;
    assign almost_full = (count >= (AW+1)'(ALMOST_FULL));

    // Storage array carries no reset: its contents are meaningless until the
    // pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. The fill
    // counter moves by push minus pop, so simultaneous push and pop leave it
    // unchanged even when full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Delayed copy of out_ready, only consulted when ready latency is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_d <= 1'b0;
        end else begin
            ready_d <= out_ready;
        end
    end

    // Drop reporting. A drop in the same cycle as a clear takes priority, so
    // the counter restarts at one rather than losing the new event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_fpga_ddr3_st_timing_adapter_buf.sv
// ---------------------------------------------------------------------------
// Bench for fpga_ddr3_st_timing_adapter_buf. Two instances (ready latency 0
// and 1) share the same stimulus; a queue-based reference model tracks each
// one and is compared against every output on every falling edge.
// ---------------------------------------------------------------------------
module tb_fpga_ddr3_st_timing_adapter_buf;

    localparam int DW   = 8;
    localparam int DEP  = 16;
    localparam int AFUL = 12;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        clear_overflow;

    logic        o_valid [2];
    logic [7:0]  o_data  [2];
    logic [4:0]  o_fill  [2];
    logic        o_afull [2];
    logic        o_ovf   [2];
    logic [15:0] o_drops [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, one set per instance
    logic [7:0]  mq    [2][$];
    logic        mrd   [2];
    logic        movf  [2];
    logic [15:0] mdrop [2];

    logic [7:0]  obs0 [$];

    fpga_ddr3_st_timing_adapter_buf #(
        .DATA_W(DW), .DEPTH(DEP), .READY_LATENCY(0), .ALMOST_FULL(AFUL)
    ) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_valid[0]), .out_data(o_data[0]), .out_ready(out_ready),
        .fill_level(o_fill[0]), .almost_full(o_afull[0]),
        .overflow(o_ovf[0]), .clear_overflow(clear_overflow),
        .drop_count(o_drops[0])
    );

    fpga_ddr3_st_timing_adapter_buf #(
        .DATA_W(DW), .DEPTH(DEP), .READY_LATENCY(1), .ALMOST_FULL(AFUL)
    ) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_valid[1]), .out_data(o_data[1]), .out_ready(out_ready),
        .fill_level(o_fill[1]), .almost_full(o_afull[1]),
        .overflow(o_ovf[1]), .clear_overflow(clear_overflow),
        .drop_count(o_drops[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: a beat is presented whenever the queue is non-empty (and, for
    // latency 1, the sink was ready last cycle); it leaves the queue when the
    // sink takes it; an arriving beat enters unless the queue is full and
    // nothing left this cycle, in which case it is counted as a drop.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                mrd[k]   = 1'b0;
                movf[k]  = 1'b0;
                mdrop[k] = 16'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit pres, tk, isfull, dr;
                pres   = (mq[k].size() != 0) && ((k == 0) || mrd[k]);
                tk     = pres && ((k == 1) || out_ready);
                isfull = (mq[k].size() == DEP);
                dr     = in_valid && isfull && !tk;
                if (tk) void'(mq[k].pop_front());
                if (in_valid && !dr) mq[k].push_back(in_data);
                if (dr) begin
                    movf[k] = 1'b1;
                    if (clear_overflow) mdrop[k] = 16'd1;
                    else if (mdrop[k] < 16'hFFFF) mdrop[k] = mdrop[k] + 16'd1;
                end else if (clear_overflow) begin
                    movf[k]  = 1'b0;
                    mdrop[k] = 16'd0;
                end
                mrd[k] = out_ready;
            end
        end
    end

    // Per-cycle comparison of both instances against the model, plus a log
    // of beats accepted from the latency-0 instance.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit ev;
            ev = (mq[k].size() != 0) && ((k == 0) || mrd[k]);
            check($sformatf("out_valid[%0d]", k), 32'(o_valid[k]), 32'(ev));
            if (ev) check($sformatf("out_data[%0d]", k), 32'(o_data[k]), 32'(mq[k][0]));
            check($sformatf("fill_level[%0d]", k), 32'(o_fill[k]), 32'(mq[k].size()));
            check($sformatf("almost_full[%0d]", k), 32'(o_afull[k]), 32'(mq[k].size() >= AFUL));
            check($sformatf("overflow[%0d]", k), 32'(o_ovf[k]), 32'(movf[k]));
            check($sformatf("drop_count[%0d]", k), 32'(o_drops[k]), 32'(mdrop[k]));
        end
        if (!reset && o_valid[0] && out_ready) obs0.push_back(o_data[0]);
    end

    // Drive one cycle of inputs; returns 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic rdy, input logic clr);
        in_valid       = iv;
        in_data        = d;
        out_ready      = rdy;
        clear_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        int pat [5];
        int cnt;
        logic [7:0] rl1_seen [$];
        pat = '{1, 0, 1, 1, 0};

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("reset out_valid", 32'(o_valid[0]), 32'd0);
        checkOutput("reset fill", 32'(o_fill[0]), 32'd0);
        checkOutput("reset overflow", 32'(o_ovf[0]), 32'd0);
        checkOutput("reset drops", 32'(o_drops[0]), 32'd0);

        // Streaming 0x01..0x05 with sink always ready
        obs0.delete();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
            if (i == 1) begin
                checkOutput("first beat valid", 32'(o_valid[0]), 32'd1);
                checkOutput("first beat data", 32'(o_data[0]), 32'h01);
            end
        end
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("stream count", 32'(obs0.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs0.size(); i++)
            checkOutput("stream order", 32'(obs0[i]), 32'(i + 1));
        checkOutput("stream drained", 32'(o_fill[0]), 32'd0);

        // Fill past capacity with the sink stalled
        obs0.delete();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 10) checkOutput("afull at 11", 32'(o_afull[0]), 32'd0);
            if (i == 11) checkOutput("afull at 12", 32'(o_afull[0]), 32'd1);
        end
        checkOutput("full fill", 32'(o_fill[0]), 32'd16);
        checkOutput("full overflow", 32'(o_ovf[0]), 32'd1);
        checkOutput("full drops", 32'(o_drops[0]), 32'd4);

        // Clear coinciding with a drop, then clear alone
        applyStimulus(1'b1, 8'h50, 1'b0, 1'b1);
        checkOutput("clr+drop overflow", 32'(o_ovf[0]), 32'd1);
        checkOutput("clr+drop drops", 32'(o_drops[0]), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clear overflow", 32'(o_ovf[0]), 32'd0);
        checkOutput("clear drops", 32'(o_drops[0]), 32'd0);

        // Push and pop together while full
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hE0 + i), 1'b1, 1'b0);
        checkOutput("pushpop fill", 32'(o_fill[0]), 32'd16);
        checkOutput("pushpop overflow", 32'(o_ovf[0]), 32'd0);
        checkOutput("pushpop drops", 32'(o_drops[0]), 32'd0);
        repeat (25) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain count", 32'(obs0.size()), 32'd19);
        for (int i = 0; i < 19 && i < obs0.size(); i++)
            checkOutput("drain order", 32'(obs0[i]), (i < 16) ? 32'(i) : 32'(8'hE0 + i - 16));

        // Ready latency 1: toggle ready with 8 beats queued
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cnt = 0;
        for (int j = 0; j < 5; j++) begin
            in_valid  = 1'b0;
            out_ready = pat[j][0];
            @(negedge clk);
            if (o_valid[1]) begin
                cnt++;
                rl1_seen.push_back(o_data[1]);
            end
            @(posedge clk);
            #1;
        end
        checkOutput("rl1 transfers", 32'(cnt), 32'd3);
        for (int i = 0; i < 3 && i < rl1_seen.size(); i++)
            checkOutput("rl1 order", 32'(rl1_seen[i]), 32'(8'h30 + i));
        checkOutput("rl1 fill", 32'(o_fill[1]), 32'd5);

        // Drop counter saturation
        repeat (70020) applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        checkOutput("sat drops0", 32'(o_drops[0]), 32'hFFFF);
        checkOutput("sat drops1", 32'(o_drops[1]), 32'hFFFF);

        // Partial drain to 9 entries, then asynchronous reset mid-cycle
        repeat (7) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pre-reset fill", 32'(o_fill[0]), 32'd9);
        checkOutput("pre-reset overflow", 32'(o_ovf[0]), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async out_valid", 32'(o_valid[0]), 32'd0);
        checkOutput("async fill", 32'(o_fill[0]), 32'd0);
        checkOutput("async overflow", 32'(o_ovf[0]), 32'd0);
        checkOutput("async drops", 32'(o_drops[0]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs0.delete();
        repeat (2) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post-reset count", 32'(obs0.size()), 32'd1);
        if (obs0.size() > 0) checkOutput("post-reset data", 32'(obs0[0]), 32'hAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
